// File: rtl/div_pkg.sv
// Shared types and constants for the shared restoring divider controller.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 4;

    // Wide all-ones pattern; users slice it down to their operand width.
    localparam logic [63:0] DIV_DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_rr_arb2.sv
// Two-way round-robin grant: when both requesters are valid, the one not
// named by ptr wins; a lone valid requester always wins.
module div_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        grant    = 2'b00;
        grant_id = 1'b0;
        if (valid == 2'b11) begin
            grant_id = ~ptr;
        end else begin
            grant_id = valid[1];
        end
        if (enable && (valid != 2'b00)) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative restoring divider between two requesters.
// Optional macro DIV_FASTPATH_EN: divisor==1 or dividend<divisor finish in one edge.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_quotient,
    output logic [WIDTH-1:0] resp_remainder,
    output logic             resp_dbz,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state;
    logic             rr_ptr;
    logic             id_q;
    logic             dbz_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor_q;

    logic [1:0]       grant;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    div_rr_arb2 u_arb (
        .valid    ({req1_valid, req0_valid}),
        .enable   (state == IDLE),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req0_ready   = grant[0];
    assign req1_ready   = grant[1];
    assign accept       = |grant;
    assign sel_dividend = grant_id ? req1_dividend : req0_dividend;
    assign sel_divisor  = grant_id ? req1_divisor  : req0_divisor;

    // One restoring step: the partial remainder needs one extra bit after the shift.
    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    always_comb begin
        shifted_rem = {rem, quo[WIDTH-1]};
        step_quo    = {quo[WIDTH-2:0], 1'b0};
        step_rem    = WIDTH'(shifted_rem);
        if (shifted_rem >= {1'b0, divisor_q}) begin
            step_rem    = WIDTH'(shifted_rem - {1'b0, divisor_q});
            step_quo[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= 1'b1;
            id_q           <= 1'b0;
            dbz_q          <= 1'b0;
            cnt            <= '0;
            quo            <= '0;
            rem            <= '0;
            divisor_q      <= '0;
            resp_valid     <= 1'b0;
            resp_id        <= 1'b0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_dbz       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr    <= grant_id;
                        id_q      <= grant_id;
                        divisor_q <= sel_divisor;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        dbz_q     <= 1'b0;
                        if (sel_divisor == '0) begin
                            quo   <= DIV_DBZ_QUOTIENT[WIDTH-1:0];
                            rem   <= sel_dividend;
                            dbz_q <= 1'b1;
                            state <= DONE;
`ifdef DIV_FASTPATH_EN
                        end else if (sel_divisor == WIDTH'(1)) begin
                            quo   <= sel_dividend;
                            rem   <= '0;
                            state <= DONE;
                        end else if (sel_dividend < sel_divisor) begin
                            quo   <= '0;
                            rem   <= sel_dividend;
                            state <= DONE;
`endif
                        end else begin
                            quo   <= sel_dividend;
                            rem   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo <= step_quo;
                    rem <= step_rem;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!resp_valid) begin
                        resp_valid     <= 1'b1;
                        resp_id        <= id_q;
                        resp_quotient  <= quo;
                        resp_remainder <= rem;
                        resp_dbz       <= dbz_q;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl: directed scenarios plus random
// operations checked against an arithmetic reference model.
module tb_div_share_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_dividend, req0_divisor;
    logic [W-1:0] req1_dividend, req1_divisor;
    logic         resp_valid, resp_ready, resp_id, resp_dbz, busy;
    logic [W-1:0] resp_quotient, resp_remainder;

    int checks = 0;
    int errors = 0;
    bit mptr;

    div_share_ctrl #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_dividend  (req0_dividend),
        .req0_divisor   (req0_divisor),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_dividend  (req1_dividend),
        .req1_divisor   (req1_divisor),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_dbz       (resp_dbz),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operands.
    function automatic int exp_quot(input int a, input int b);
        return (b == 0) ? (1 << W) - 1 : a / b;
    endfunction

    function automatic int exp_rem(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int exp_lat(input int a, input int b);
        if (b == 0) return 1;
`ifdef DIV_FASTPATH_EN
        if (b == 1 || a < b) return 1;
`endif
        return W + 1;
    endfunction

    function automatic bit exp_winner(input bit v0, input bit v1);
        if (v0 && v1) return ~mptr;
        return v1;
    endfunction

    task automatic drive(input bit id, input int a, input int b);
        if (id) begin
            req1_valid = 1'b1; req1_dividend = W'(a); req1_divisor = W'(b);
        end else begin
            req0_valid = 1'b1; req0_dividend = W'(a); req0_divisor = W'(b);
        end
    endtask

    task automatic check_ready(input string tag, input bit id);
        check({tag, "_rdy_win"}, id ? req1_ready : req0_ready, 1);
        check({tag, "_rdy_lose"}, id ? req0_ready : req1_ready, 0);
    endtask

    // Accept on the next edge, then wait for and check the response.
    task automatic finish_op(input string tag, input bit id, input int a, input int b,
                             input int stall);
        int edges;
        resp_ready = (stall == 0);
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b0; req1_dividend = W'($urandom); req1_divisor = W'($urandom);
        end else begin
            req0_valid = 1'b0; req0_dividend = W'($urandom); req0_divisor = W'($urandom);
        end
        mptr = id;
        edges = 0;
        while (!resp_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_lat"}, edges, exp_lat(a, b));
        check({tag, "_id"}, resp_id, id);
        check({tag, "_q"}, resp_quotient, exp_quot(a, b));
        check({tag, "_r"}, resp_remainder, exp_rem(a, b));
        check({tag, "_dbz"}, resp_dbz, (b == 0));
        check({tag, "_busy"}, busy, 1);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, "_hold_v"}, resp_valid, 1);
            check({tag, "_hold_qr"}, {resp_quotient, resp_remainder},
                  {W'(exp_quot(a, b)), W'(exp_rem(a, b))});
            check({tag, "_hold_rdy"}, {busy, req0_ready, req1_ready}, 3'b100);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_done_v"}, resp_valid, 0);
        check({tag, "_done_busy"}, busy, 0);
    endtask

    task automatic single_op(input string tag, input bit id, input int a, input int b,
                             input int stall);
        drive(id, a, b);
        #1;
        check_ready(tag, id);
        finish_op(tag, id, a, b, stall);
    endtask

    task automatic both_op(input string tag, input int a0, input int b0,
                           input int a1, input int b1);
        bit win;
        drive(1'b0, a0, b0);
        drive(1'b1, a1, b1);
        #1;
        win = exp_winner(1'b1, 1'b1);
        check_ready({tag, "_first"}, win);
        if (win) finish_op({tag, "_first"}, 1'b1, a1, b1, 1);
        else     finish_op({tag, "_first"}, 1'b0, a0, b0, 1);
        check_ready({tag, "_second"}, ~win);
        if (win) finish_op({tag, "_second"}, 1'b0, a0, b0, 0);
        else     finish_op({tag, "_second"}, 1'b1, a1, b1, 0);
    endtask

    initial begin
        int a, b, a1, b1;
        bit id;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; resp_ready = 1;
        req0_dividend = 0; req0_divisor = 0; req1_dividend = 0; req1_divisor = 0;
        mptr = 1'b1;
        #12;
        check("reset_outs", {resp_valid, resp_id, resp_dbz, busy, resp_quotient, resp_remainder}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        single_op("t1_8div2", 1'b0, 8, 2, 0);
        single_op("t2_9div3", 1'b1, 9, 3, 0);
        both_op("t3_a", 10, 6, 12, 6);
        single_op("t3_prime", 1'b0, 4, 3, 0);
        both_op("t3_b", 10, 6, 12, 6);
        single_op("t4_dbz", 1'b0, 13, 0, 0);
        single_op("t5_stall", 1'b0, 13, 7, 6);

        // Reset during CALC discards the operation.
        drive(1'b0, 12, 6);
        #1;
        check_ready("t6_pre", 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", {resp_valid, resp_id, resp_dbz, busy, resp_quotient, resp_remainder}, 0);
        mptr = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("t6_rst_hold", {resp_valid, busy}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_post_idle", {resp_valid, busy}, 0);
        single_op("t6_7div2", 1'b1, 7, 2, 0);
        single_op("t6_5div1", 1'b0, 5, 1, 0);
        single_op("edge_15div15", 1'b1, 15, 15, 0);
        single_op("edge_15div1", 1'b0, 15, 1, 0);
        single_op("edge_0div5", 1'b1, 0, 5, 0);

        for (int i = 0; i < 12; i++) begin
            id = 1'($urandom);
            a  = int'($urandom_range(0, 15));
            b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
            single_op("rand_single", id, a, b, int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 4; i++) begin
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            a1 = int'($urandom_range(0, 15));
            b1 = int'($urandom_range(1, 15));
            both_op("rand_both", a, b, a1, b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
